// File: rtl/cayde_fetch_unit.sv
// Instruction fetch: throttled requests, redirect flush and an in-order instruction buffer.
// Define CAYDE_FETCH_PERF_EN to add the perf_fetched pop counter output.
module cayde_fetch_unit #(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] instr_pc
`ifdef CAYDE_FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched
`endif
);

    localparam int AW = (DEPTH > 2) ? 2 : 1;
    localparam int CW = AW + 1;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   rsp_pc_q, rsp_pc_d;
    logic [AW-1:0]     head_q, head_d;
    logic [AW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     disc_q, disc_d;
    logic [CW:0]       inflight;
    logic              grant;
    logic              push;
    logic              pop;
    logic [PC_W-1:0]   target;

    logic [31:0]       buf_data [DEPTH];
    logic [PC_W-1:0]   buf_pc   [DEPTH];

    assign inflight    = {1'b0, outst_q} + {1'b0, count_q};
    assign imem_req    = ~rst && (state_q == RUN) && (inflight < (CW+1)'(DEPTH));
    assign imem_addr   = pc_q;
    assign grant       = imem_req & imem_gnt;
    assign instr_valid = (count_q != '0);
    assign push        = imem_rvalid & (state_q == RUN) & ~redirect_valid;
    assign pop         = instr_valid & instr_ready & ~redirect_valid;
    assign target      = redirect_pc & ~PC_W'(3);
    assign instr       = instr_valid ? buf_data[head_q] : '0;
    assign instr_pc    = instr_valid ? buf_pc[head_q] : '0;

    // Outstanding responses in RUN belong to consecutive addresses from rsp_pc.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        head_d   = head_q;
        tail_d   = tail_q;
        disc_d   = disc_q;
        outst_d  = outst_q + CW'(grant) - CW'(imem_rvalid);
        count_d  = count_q + CW'(push) - CW'(pop);
        if (grant) pc_d = pc_q + PC_W'(4);
        if (push) begin
            tail_d   = tail_q + AW'(1);
            rsp_pc_d = rsp_pc_q + PC_W'(4);
        end
        if (pop) head_d = head_q + AW'(1);
        if (state_q == FLUSH && imem_rvalid) disc_d = disc_q - CW'(1);
        if (state_q == FLUSH && disc_d == '0) state_d = RUN;
        if (redirect_valid) begin
            pc_d     = target;
            rsp_pc_d = target;
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            disc_d   = outst_d;
            state_d  = (outst_d != '0) ? FLUSH : RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            outst_q  <= '0;
            disc_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            outst_q  <= outst_d;
            disc_q   <= disc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[tail_q] <= imem_rdata;
            buf_pc[tail_q]   <= rsp_pc_q;
        end
    end

`ifdef CAYDE_FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) perf_fetched <= '0;
        else if (pop) perf_fetched <= perf_fetched + 32'd1;
    end
`endif

endmodule
